// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I datapath.
// Drives the datapath selects/enables, counts retired instructions and traps on
// an illegal opcode or on a memory access that is never acknowledged.
//
// state  | meaning
// FETCH  | read the instruction at PC; load IR when mem_ready
// DECODE | classify the opcode; illegal opcodes go to TRAP
// EXEC   | ALU op; branch/JAL/JALR/LUI finish and retire here
// MEM    | load/store data access, held until mem_ready
// WB     | register write-back, PC+4, retire
// TRAP   | frozen until reset; trap_cause says why
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Down-counter reloaded with TIMEOUT-1; terminal count 0 while still waiting traps.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (TIMEOUT > 1) ? WAIT_W'(TIMEOUT - 1) : '0;

  state_t            st, nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [6:0]        opc;
  logic              is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic              legal, access, timeout, retire;
  logic              unused_instr;

  assign opc          = Instr[6:0];
  assign unused_instr = ^Instr[31:7];
  assign is_r         = (opc == OP_R);
  assign is_i         = (opc == OP_I);
  assign is_ld        = (opc == OP_LD);
  assign is_st        = (opc == OP_ST);
  assign is_br        = (opc == OP_BR);
  assign is_jal       = (opc == OP_JAL);
  assign is_jalr      = (opc == OP_JALR);
  assign is_lui       = (opc == OP_LUI);
  assign is_auipc     = (opc == OP_AUIPC);
  assign legal        = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;

  assign access  = (st == FETCH) || (st == MEM);
  assign timeout = (TIMEOUT != 0) && access && !mem_ready && (wait_cnt == '0);
  assign retire  = ((st == EXEC) && (is_br | is_jal | is_jalr | is_lui)) ||
                   ((st == MEM) && mem_ready && is_st) ||
                   (st == WB);
  assign state   = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= FETCH;
      trap_cause <= 2'd0;
      instret    <= '0;
    end else begin
      st <= nxt;
      if ((st == DECODE) && !legal) trap_cause <= 2'd1;
      else if (timeout)             trap_cause <= 2'd2;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !access || mem_ready) wait_cnt <= WAIT_LOAD;
    else if (wait_cnt != '0)           wait_cnt <= wait_cnt - 1'b1;
  end

  always_comb begin
    nxt = st;
    case (st)
      FETCH:  if (mem_ready) nxt = DECODE;
              else if (timeout) nxt = TRAP;
      DECODE: nxt = legal ? EXEC : TRAP;
      EXEC:   if (is_ld | is_st) nxt = MEM;
              else if (is_r | is_i | is_auipc) nxt = WB;
              else nxt = FETCH;
      MEM:    if (mem_ready) nxt = is_ld ? WB : FETCH;
              else if (timeout) nxt = TRAP;
      WB:     nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = 2'd0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    // ALU operands stay put from EXEC through MEM/WB so the result is stable.
    if ((st == EXEC) || (st == MEM) || (st == WB)) begin
      if (is_r)                    alu_op = 2'd2;
      if (is_i)                    begin alu_op = 2'd2; alu_src_b = 1'b1; end
      if (is_ld | is_st | is_jalr) alu_src_b = 1'b1;
      if (is_auipc)                begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
    end
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      EXEC: begin
        if (is_br)   begin pc_we = 1'b1; pc_src = br_taken ? 2'd1 : 2'd0; end
        if (is_jal)  begin pc_we = 1'b1; pc_src = 2'd1; reg_we = 1'b1; wb_sel = 2'd2; end
        if (is_jalr) begin pc_we = 1'b1; pc_src = 2'd2; reg_we = 1'b1; wb_sel = 2'd2; end
        if (is_lui)  begin pc_we = 1'b1; reg_we = 1'b1; wb_sel = 2'd3; end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        pc_we        = is_st && mem_ready;
      end
      WB: begin
        reg_we = 1'b1;
        wb_sel = is_ld ? 2'd1 : 2'd0;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
    end
  end

endmodule
